uart_tx_buffered: RTL
=====================

// Module: uart_tx_buffered
// PURPOSE
//  Serial UART transmitter, directly downstream of the DataFilter byte splitter.
//  - Consumes the TxEn/TxData byte stream and emits 8N1 frames on Tx, LSB first.
//  - DataFilter emits both bytes of a 16-bit CPU word back-to-back.
//  - A small byte FIFO absorbs these bursts, so frames leave gap-free while the FIFO is non-empty.
// PARAMETERS
//  CLKS_PER_BIT  434  clk cycles per serial bit (50 MHz / 115200); must be >= 2
//  FIFO_DEPTH    4    byte FIFO entries; power of 2, >= 2
//  FIFO_AW       2    log2(FIFO_DEPTH)
// PORTS
//  clk       in   1  system clock, all logic on posedge
//  reset     in   1  synchronous, active-high reset
//  TxEn      in   1  byte strobe; one byte accepted per cycle high
//  TxData    in   8  byte to send, sampled when TxEn=1
//  Tx        out  1  serial line, idle high
//  TxBusy    out  1  1 while a frame is in progress or the FIFO is non-empty
//  TxDone    out  1  1-cycle pulse in the last cycle of each stop bit
//  FifoFull  out  1  FIFO holds FIFO_DEPTH bytes
//  Overflow  out  1  1-cycle pulse: a byte was dropped
// BEHAVIOUR
//  Reset (any cycle, incl. mid-frame)
//  - Next cycle: Tx=1, TxBusy=0, TxDone=0, FifoFull=0, Overflow=0.
//  - FIFO is emptied, FSM goes to IDLE, bit and baud counters clear. A partial frame is abandoned.
//  FIFO
//  - Push when TxEn=1 and not full. Pop is FSM-driven.
//  - Push and pop in the same cycle are both honoured; count is unchanged.
//  - TxEn=1 while full: byte dropped, even if a pop occurs that cycle.
//  - Overflow is registered; it pulses the cycle after the dropped TxEn.
//  - Pointers wrap modulo FIFO_DEPTH. A count of FIFO_AW+1 bits distinguishes full from empty.
//  FSM states IDLE, START, DATA, STOP
//  - IDLE: if FIFO non-empty, pop and load the shift register, then go to START.
//  - START: Tx=0 for CLKS_PER_BIT cycles, then go to DATA.
//  - DATA: Tx=shreg[0] each bit; shift right after each CLKS_PER_BIT. After 8 bits, go to STOP.
//  - STOP: Tx=1 for CLKS_PER_BIT cycles. In the last cycle, TxDone=1.
//    If the FIFO is non-empty in that cycle: pop, load, go to START.
//    Otherwise go to IDLE.
//  Baud counter
//  - Counts 0..CLKS_PER_BIT-1 and resets on each bit boundary and on state entry.
//  Latency and timing
//  - TxEn sampled in cycle N, FIFO empty and FSM idle: pop in N+1; Tx falls in N+2.
//  - Frame length is exactly 10*CLKS_PER_BIT cycles.
//  - Consecutive queued frames are contiguous, with no idle cycles between them.
//  Outputs
//  - Tx is registered (glitch-free).
//  - TxBusy = (state!=IDLE) | ~empty.
//  - A TxEn during a frame never disturbs the frame in flight.
// STRUCTURE
//  - uart_defs.vh (shared with the RX side): FSM state localparams (IDLE=0, START=1, DATA=2, STOP=3),
//    frame constants (DATA_BITS=8, STOP_BITS=1), default CLKS_PER_BIT.
//  - Sub-module uart_byte_fifo: sync FIFO with push/pop/dout/full/empty, parameterised by FIFO_AW.
//  - Top: FSM, baud counter, 3-bit bit counter, 8-bit shift register, output regs.
// TESTING  (bench overrides CLKS_PER_BIT=16; clk period 100 ns)
//  1 Single byte 8'h12 at cycle N
//    -> Tx=0 over N+2..N+17.
//    -> Data bits 0,1,0,0,1,0,0,0, 16 cycles each.
//    -> Stop high; TxDone pulse at N+161; TxBusy falls at N+162.
//  2 8'h12 at N, 8'h34 at N+1 (DataFilter split pattern)
//    -> Two contiguous frames, 320 cycles total.
//    -> TxDone at N+161 and N+321.
//    -> Second start bit begins at N+162.
//  3 Six TxEn on consecutive cycles N..N+5, bytes 01..06, FIFO_DEPTH=4
//    -> FifoFull=1 from N+5.
//    -> Overflow pulse at N+6.
//    -> Bytes 01..05 sent in order; 06 never appears.
//  4 Byte 8'hA5 sent; reset asserted for 1 cycle during the 4th data bit
//    -> Tx=1, TxBusy=0 the next cycle.
//    -> A subsequent 8'h3C is framed correctly from scratch.
//  5 Edge data 8'h00 then 8'hFF
//    -> All-low data with high stop, then all-high data.
//    -> Start bit is still low and exactly 16 cycles.
//  6 Idle 1000 cycles with no TxEn after reset
//    -> Tx constantly 1; TxBusy, TxDone and Overflow stay 0.

Source files
------------

// File: rtl/uart_tx_buffered_pkg.sv
// Shared UART transmit definitions: FSM state encoding and frame constants.
package uart_tx_buffered_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_tx_buffered_byte_fifo.sv
// Synchronous byte FIFO; an extra count bit separates full from empty.
module uart_tx_buffered_byte_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic [7:0] din_i,
    input  logic       pop_i,
    output logic [7:0] dout_o,
    output logic       full_o,
    output logic       empty_o
);

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wptr_q, wptr_d;
    logic [FIFO_AW-1:0] rptr_q, rptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               do_push, do_pop;

    assign full_o  = (count_q == (FIFO_AW+1)'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign dout_o  = mem_q[rptr_q];

    // A push while full is refused even if a pop frees a slot in the same cycle.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a start/data/stop FSM,
// with back-to-back frames when bytes are queued.
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4,
    parameter int FIFO_AW      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       TxEn,
    input  logic [7:0] TxData,
    output logic       Tx,
    output logic       TxBusy,
    output logic       TxDone,
    output logic       FifoFull,
    output logic       Overflow
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic              ovf_q, ovf_d;
    logic              baud_last, load;
    logic              fifo_empty, fifo_full;
    logic [7:0]        fifo_dout;

    uart_tx_buffered_byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .FIFO_AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (TxEn),
        .din_i   (TxData),
        .pop_i   (load),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign baud_last = (baud_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = START;
            START:   if (baud_last) state_d = DATA;
            DATA:    if (baud_last && bit_q == BIT_LAST) state_d = STOP;
            STOP:    if (baud_last) state_d = fifo_empty ? IDLE : START;
            default: state_d = IDLE;
        endcase
    end

    // Loading in the final stop cycle chains the next frame with no idle gap.
    always_comb begin
        load   = ((state_q == IDLE) || (state_q == STOP && baud_last)) && !fifo_empty;
        TxDone = (state_q == STOP) && baud_last;
        TxBusy = (state_q != IDLE) || !fifo_empty;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        baud_d  = (state_q == IDLE || baud_last) ? '0 : baud_q + 1'b1;
        bit_d   = (state_q == DATA) ? (baud_last ? bit_q + 1'b1 : bit_q) : 3'd0;
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = fifo_dout;
        end else if (state_q == DATA && baud_last) begin
            shreg_d = shreg_q >> 1;
        end
        ovf_d   = TxEn & fifo_full;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_q <= '0;
            bit_q  <= '0;
            tx_q   <= 1'b1;
            ovf_q  <= 1'b0;
        end else begin
            baud_q <= baud_d;
            bit_q  <= bit_d;
            tx_q   <= tx_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign Tx       = tx_q;
    assign FifoFull = fifo_full;
    assign Overflow = ovf_q;

endmodule
